// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*SEL_W-1:0] req_sel;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One operation at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (handshake).
// Optional macro ALU_ARB_PRIO_EN: requester 0 always wins when valid and does not
// advance the round-robin pointer; other requesters stay round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               ptr_adv;
  logic               any_req;
  logic               grant;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [SEL_W-1:0]   pick_sel;
  logic [WIDTH-1:0]   cap_data;
  logic               cap_carry;

  // First valid requester at or after ptr, wrapping at NUM_REQ-1.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] pick;
    int               idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (vld[PTR_W'(idx)]) begin
        pick = PTR_W'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign any_req = |bus.req_valid;
  assign grant   = (state == IDLE) && any_req;

  // Winner selection and whether this grant moves the round-robin pointer.
  always_comb begin
    win     = rr_pick(bus.req_valid, rr_ptr);
    ptr_adv = 1'b1;
`ifdef ALU_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      win     = {PTR_W{1'b0}};
      ptr_adv = 1'b0;
    end else begin
      win     = rr_pick(bus.req_valid, rr_ptr);
      ptr_adv = 1'b1;
    end
`endif
    ptr_nxt = (win == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (win + PTR_W'(1));
  end

  // Operand mux: route the winner's packed operands toward the ALU registers.
  always_comb begin
    pick_a   = {WIDTH{1'b0}};
    pick_b   = {WIDTH{1'b0}};
    pick_sel = {SEL_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_a   = pick_a   | ({WIDTH{win == PTR_W'(i)}} & bus.req_a[i*WIDTH +: WIDTH]);
      pick_b   = pick_b   | ({WIDTH{win == PTR_W'(i)}} & bus.req_b[i*WIDTH +: WIDTH]);
      pick_sel = pick_sel | ({SEL_W{win == PTR_W'(i)}} & bus.req_sel[i*SEL_W +: SEL_W]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; EXEC always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready[owner]) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; req_ready is forced low while reset is asserted so every
  // output reads 0 during reset even with requests pending.
  always_comb begin
    bus.req_ready = {NUM_REQ{1'b0}};
    bus.rsp_valid = {NUM_REQ{1'b0}};
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (grant && rst_n) begin
          bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        end else begin
          bus.req_ready = {NUM_REQ{1'b0}};
        end
      end
      EXEC: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: latch operands on grant, capture ALU result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= {WIDTH{1'b0}};
      alu_b     <= {WIDTH{1'b0}};
      alu_sel   <= {SEL_W{1'b0}};
      owner     <= {PTR_W{1'b0}};
      rr_ptr    <= {PTR_W{1'b0}};
      cap_data  <= {WIDTH{1'b0}};
      cap_carry <= 1'b0;
    end else begin
      if (grant) begin
        alu_a   <= pick_a;
        alu_b   <= pick_b;
        alu_sel <= pick_sel;
        owner   <= win;
        if (ptr_adv) begin
          rr_ptr <= ptr_nxt;
        end
      end
      if (state == EXEC) begin
        cap_data  <= alu_out;
        cap_carry <= alu_carry;
      end
    end
  end

  assign bus.rsp_data  = cap_data;
  assign bus.rsp_carry = cap_carry;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 8-bit ALU (A, B, 4-bit ALU_Sel, ALU_Out, CarryOut) among NUM_REQ requesters in the pipelined datapath.
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU from registers for one execute cycle and captures the result and carry.
- Returns the result to the owning requester over a valid/ready handshake.
- Serves one operation at a time (non-pipelined).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width; matches the ALU.
- SEL_W, 4, ALU select width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- req_sel  input  NUM_REQ*SEL_W  ALU select, packed [i*SEL_W +: SEL_W].
- alu_a  output  WIDTH  registered operand to ALU A.
- alu_b  output  WIDTH  registered operand to ALU B.
- alu_sel  output  SEL_W  registered select to ALU_Sel.
- alu_out  input  WIDTH  ALU_Out from ALU.
- alu_carry  input  1  CarryOut from ALU.
- rsp_valid  output  NUM_REQ  one-hot; result available for that requester.
- rsp_ready  input  NUM_REQ  requester accepts result.
- rsp_data  output  WIDTH  captured ALU result.
- rsp_carry  output  1  captured carry.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n); the clock port is clk.
- Reset values: all outputs 0, FSM=IDLE, round-robin pointer rr_ptr=0. Reset mid-operation abandons the operation; no response is issued.

States IDLE, EXEC, RESP:
- IDLE:
  - Winner = first requester with req_valid=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - If any request: assert req_ready[winner] combinationally this cycle.
  - Latch the winner's a, b and sel into alu_a, alu_b and alu_sel at the edge.
  - Store owner=winner; set rr_ptr=(winner+1) mod NUM_REQ; go to EXEC.
  - No request: remain in IDLE; req_ready=0.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from registers.
  - At the edge, capture rsp_data<=alu_out and rsp_carry<=alu_carry, then go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_carry hold.
  - When rsp_ready[owner]=1: rsp_valid drops next edge and the FSM returns to IDLE.
  - rsp_ready bits of non-owners are ignored.

Timing and sharing rules:
- Latency: accept at cycle T; rsp_valid at T+2; minimum issue interval 3 cycles per operation.
- req_ready is 0 outside IDLE. Requests pending during EXEC/RESP are held by requesters and are not lost.
- Requests arriving while the FSM is in RESP are arbitrated in the IDLE cycle after acceptance; there is no bypass.
- alu_a, alu_b and alu_sel hold their last values after EXEC; they change only on a grant.
- A single requester, requesting continuously, is granted every operation; the pointer wraps at NUM_REQ-1 to 0.
- All arithmetic, carry and select decoding are done by the ALU. The arbiter never alters operands or results.

Optional Feature:
- Macro ALU_ARB_PRIO_EN.
- Defined: requester 0 is high-priority and is granted whenever req_valid[0]=1 in IDLE, regardless of rr_ptr. rr_ptr advances only on grants to requesters 1..NUM_REQ-1; remaining requesters use round-robin as above.
- Undefined: pure round-robin for all requesters, as specified above.

Test Plan:
- Single add: requester 1 with a=8'h0A, b=8'h02, sel=4'h0 (ALU add); rsp_ready=1.
  - req_ready[1] pulses at T.
  - rsp_valid=4'b0010 at T+2 with rsp_data=8'h0C and rsp_carry=0.
  - busy returns to 0 at T+3.
- Carry out: requester 2 with a=8'hF6, b=8'h0A, sel=4'h0 -> rsp_data=8'h00, rsp_carry=1.
- Round-robin fairness: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0. Grants are 3 cycles apart; no requester is granted twice before all others are served.
- Response backpressure: rsp_ready[owner]=0 for 5 cycles while other requests are pending.
  - rsp_valid and rsp_data stay stable; all req_ready stay 0.
  - Once rsp_ready=1, the next grant occurs 1 cycle after acceptance.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - All outputs go to 0 immediately (asynchronous); no rsp_valid is issued.
  - After release, the first grant goes to requester 0 (rr_ptr=0).
- ALU_ARB_PRIO_EN defined: requesters 0 and 3 both valid continuously -> requester 0 is granted every operation.
  - After req_valid[0] drops, requester 3 is granted.
  - Without the macro, grants alternate 0,3,0,3.
